// File: rtl/ni_flit_receiver.sv
// ni_flit_receiver: ejection-port receiver that checks heads and serialises flit payloads into 16-bit SRAM writes.
// Optional build macro NI_RX_ADDR_CHECK_EN: heads not addressed to LOCAL_ID are dropped up to their tail.
module ni_flit_receiver #(
    parameter int ADDR_W = 10,
    parameter logic [7:0] LOCAL_ID = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [255:0]      flit_in,
    input  logic              flit_valid,
    output logic              flit_ready,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [7:0]        pkt_src,
    output logic [7:0]        pkt_words
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_WRITE, S_DONE
`ifdef NI_RX_ADDR_CHECK_EN
        , S_DROP
`endif
    } state_t;
    state_t state, next, head_next;
    logic [7:0] n;
    logic [ADDR_W-1:0] base;
    logic [239:0] payload;
    logic [3:0] idx, last, k;
    logic [7:0] remain;
    logic tail_q, err_q, err_ev, accept, is_head, is_data, is_tail, is_inv;
    assign accept  = flit_valid && flit_ready;
    assign is_head = flit_in[255:254] == 2'b01;
    assign is_data = flit_in[255];
    assign is_tail = flit_in[255:254] == 2'b11;
    assign is_inv  = flit_in[255:254] == 2'b00;
    assign remain  = n - pkt_words;
    assign k       = remain > 8'd15 ? 4'd15 : remain[3:0];
`ifdef NI_RX_ADDR_CHECK_EN
    assign head_next = flit_in[245:238] == LOCAL_ID ? S_WAIT : S_DROP;
`else
    logic unused_dest;
    assign unused_dest = ^{flit_in[245:238], LOCAL_ID};
    assign head_next = S_WAIT;
`endif
    assign err_ev = accept && (state == S_IDLE ? !is_head : state == S_WAIT ? (is_head || is_inv) : is_tail);
    assign flit_ready = !reset && !(state == S_WRITE || state == S_DONE);
    assign sram_we    = state == S_WRITE;
    assign sram_addr  = base + ADDR_W'(pkt_words);
    assign sram_wdata = payload[{idx, 4'b0} +: 16];
    assign pkt_done   = state == S_DONE;
    assign pkt_err    = err_q || (pkt_done && pkt_words < n);
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= next;
    end
    // next state: a data flit with nothing left to write skips WRITE entirely
    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = accept && is_head ? head_next : S_IDLE;
            S_WAIT:  if (accept) next = is_head ? head_next : !is_data ? S_WAIT : k != 4'd0 ? S_WRITE : is_tail ? S_DONE : S_WAIT;
            S_WRITE: if (idx == last) next = tail_q ? S_DONE : S_WAIT;
`ifdef NI_RX_ADDR_CHECK_EN
            S_DROP:  if (accept && is_tail) next = S_IDLE;
`endif
            default: next = S_IDLE;
        endcase
    end
    // packet context, payload buffer, word counters and the registered error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            n <= '0;
            base <= '0;
            payload <= '0;
            idx <= '0;
            last <= '0;
            tail_q <= 1'b0;
            err_q <= 1'b0;
            pkt_src <= '0;
            pkt_words <= '0;
        end else begin
            err_q <= err_ev;
            if (accept && is_head) begin
                pkt_src <= flit_in[253:246];
                n <= flit_in[237:230];
                base <= base_addr;
                pkt_words <= '0;
            end
            if (accept && is_data && state == S_WAIT) begin
                payload <= flit_in[239:0];
                idx <= '0;
                last <= k - 4'd1;
                tail_q <= is_tail;
            end
            if (state == S_WRITE) begin
                pkt_words <= pkt_words + 8'd1;
                idx <= idx + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_ni_flit_receiver.sv
// tb_ni_flit_receiver: table-driven packets, cycle-exact corner sequences and random traffic against a packet-level model.
module tb_ni_flit_receiver;
    localparam int ADDR_W = 10;
    localparam logic [7:0] LOCAL_ID = 8'h00;
    logic clk = 1'b0, reset = 1'b1, flit_valid = 1'b0, flit_ready;
    logic [255:0] flit_in = '0;
    logic [ADDR_W-1:0] base_addr = '0, sram_addr;
    logic sram_we, pkt_done, pkt_err;
    logic [15:0] sram_wdata;
    logic [7:0] pkt_src, pkt_words;
    ni_flit_receiver #(.ADDR_W(ADDR_W), .LOCAL_ID(LOCAL_ID)) dut (
        .clk(clk), .reset(reset), .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .base_addr(base_addr), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_src(pkt_src), .pkt_words(pkt_words)
    );
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [25:0] act_q[$];
    int done_cnt = 0, err_cnt = 0;
    always @(negedge clk) if (!reset) begin
        if (sram_we) act_q.push_back({sram_addr, sram_wdata});
        if (pkt_done) done_cnt++;
        if (pkt_err) err_cnt++;
    end

    logic [25:0] exp_q[$];
    bit m_in = 0;
    int m_n = 0, m_w = 0, m_done = 0, m_err = 0;
    logic [7:0] m_src = '0;
    logic [9:0] m_base = '0;
    function automatic void model(input logic [255:0] f, input logic [9:0] b);
        int k;
        case (f[255:254])
            2'b01: begin
                if (m_in) m_err++;
                m_in = 1; m_n = int'(f[237:230]); m_w = 0; m_base = b; m_src = f[253:246];
            end
            2'b00: m_err++;
            default: if (!m_in) m_err++;
            else begin
                k = m_n - m_w;
                if (k > 15) k = 15;
                for (int i = 0; i < k; i++) exp_q.push_back({10'(int'(m_base) + m_w + i), f[i*16 +: 16]});
                m_w += k;
                if (f[254]) begin
                    m_done++;
                    if (m_w < m_n) m_err++;
                    m_in = 0;
                end
            end
        endcase
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction
    function automatic logic [255:0] mk_head(input logic [7:0] src, input logic [7:0] dest, input logic [7:0] n);
        logic [255:0] r = rnd256();
        r[255:254] = 2'b01; r[253:246] = src; r[245:238] = dest; r[237:230] = n;
        return r;
    endfunction
    function automatic logic [255:0] mk_data(input bit tail);
        logic [255:0] r = rnd256();
        r[255:254] = tail ? 2'b11 : 2'b10;
        return r;
    endfunction

    task automatic send(input logic [255:0] f, input logic [9:0] b);
        int t = 0;
        flit_in = f; base_addr = b; flit_valid = 1'b1;
        while (!flit_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            checks++; failures++;
            $display("FAIL send_timeout: flit_ready=%0b after %0d cycles required 1", flit_ready, t);
        end
        @(posedge clk);
        model(f, b);
        @(negedge clk);
        flit_valid = 1'b0; flit_in = rnd256(); base_addr = 10'($urandom);
    endtask
    task automatic clear();
        act_q.delete(); exp_q.delete();
        done_cnt = 0; err_cnt = 0; m_done = 0; m_err = 0;
    endtask
    task automatic check_model(input string tag);
        int bad = 0;
        chk({tag, "_nwrites"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            if (act_q[i] !== exp_q[i]) begin
                if (bad == 0) $display("FAIL %s_write[%0d]: got %h expected %h", tag, i, act_q[i], exp_q[i]);
                bad++;
            end
        chk({tag, "_bad_writes"}, bad, 0);
        chk({tag, "_done"}, done_cnt, m_done);
        chk({tag, "_err"}, err_cnt, m_err);
        chk({tag, "_src"}, pkt_src, m_src);
        chk({tag, "_words"}, pkt_words, m_w);
    endtask
    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, flit_ready, 0);
        chk({tag, "_we"}, sram_we, 0);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_wdata"}, sram_wdata, 0);
        chk({tag, "_done"}, pkt_done, 0);
        chk({tag, "_err"}, pkt_err, 0);
        chk({tag, "_src"}, pkt_src, 0);
        chk({tag, "_words"}, pkt_words, 0);
    endtask

    typedef struct {
        logic [9:0] base;
        logic [7:0] n;
        int nbody, writes, words, done, err;
    } row_t;
    row_t rows[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] f;
        int lows;
        rows = '{
            '{10'h040, 8'd3,   0, 3,  3,  1, 0},
            '{10'h100, 8'd20,  1, 20, 20, 1, 0},
            '{10'h200, 8'd20,  0, 15, 15, 1, 1},
            '{10'h3FE, 8'd4,   0, 4,  4,  1, 0},
            '{10'h010, 8'd0,   0, 0,  0,  1, 0},
            '{10'h020, 8'd0,   2, 0,  0,  1, 0},
            '{10'h3F0, 8'd255, 3, 60, 60, 1, 1},
            '{10'h150, 8'd30,  2, 30, 30, 1, 0},
            '{10'h160, 8'd15,  0, 15, 15, 1, 0},
            '{10'h170, 8'd16,  0, 15, 15, 1, 1}
        };
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", flit_ready, 1);

        clear();
        send(mk_head(8'h12, LOCAL_ID, 8'd3), 10'h040);
        chk("head_ready_next", flit_ready, 1);
        f = mk_data(1);
        f[47:0] = 48'hA003_A002_A001;
        send(f, 10'h155);
        chk("a_we0", sram_we, 1); chk("a_addr0", sram_addr, 10'h040); chk("a_data0", sram_wdata, 16'hA001);
        @(negedge clk);
        chk("a_addr1", sram_addr, 10'h041); chk("a_data1", sram_wdata, 16'hA002);
        @(negedge clk);
        chk("a_we2", sram_we, 1); chk("a_addr2", sram_addr, 10'h042); chk("a_data2", sram_wdata, 16'hA003);
        @(negedge clk);
        chk("a_done", pkt_done, 1); chk("a_err", pkt_err, 0); chk("a_we_off", sram_we, 0);
        chk("a_ready_done", flit_ready, 0); chk("a_src", pkt_src, 8'h12); chk("a_words", pkt_words, 3);
        @(negedge clk);
        chk("a_done_pulse", pkt_done, 0); chk("a_ready_idle", flit_ready, 1);

        clear();
        send(mk_head(8'h21, LOCAL_ID, 8'd20), 10'h0C0);
        send(mk_data(0), 10'h0);
        lows = 0;
        while (!flit_ready && lows < 40) begin lows++; @(negedge clk); end
        chk("b_ready_low_cycles", lows, 15);
        send(mk_data(1), 10'h0);
        repeat (10) @(negedge clk);
        check_model("b");

        clear();
        send(mk_data(0), 10'h0);
        chk("idle_body_err", pkt_err, 1); chk("idle_body_ready", flit_ready, 1);
        f = rnd256(); f[255:254] = 2'b00;
        send(f, 10'h0);
        chk("idle_inv_err", pkt_err, 1);
        @(negedge clk);
        chk("idle_err_pulse", pkt_err, 0); chk("idle_errs", err_cnt, 2); chk("idle_no_done", done_cnt, 0);

        clear();
        send(mk_head(8'h33, LOCAL_ID, 8'd15), 10'h080);
        send(mk_data(0), 10'h0);
        repeat (4) @(negedge clk);
        chk("r_we5", sram_we, 1); chk("r_addr5", sram_addr, 10'h084);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("r_mid");
        reset = 1'b0;
        m_in = 0; m_w = 0; m_src = '0;
        clear();
        @(negedge clk);
        send(mk_head(8'h34, LOCAL_ID, 8'd1), 10'h2A0);
        f = mk_data(1); f[15:0] = 16'hBEEF;
        send(f, 10'h0);
        chk("r_we", sram_we, 1); chk("r_addr", sram_addr, 10'h2A0); chk("r_data", sram_wdata, 16'hBEEF);
        @(negedge clk);
        chk("r_done", pkt_done, 1); chk("r_err", pkt_err, 0);
        @(negedge clk);
        check_model("r");

        for (int i = 0; i < 10; i++) begin
            logic [7:0] src;
            clear();
            src = 8'($urandom);
            send(mk_head(src, LOCAL_ID, rows[i].n), rows[i].base);
            for (int j = 0; j < rows[i].nbody; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(mk_data(0), 10'h0);
            end
            send(mk_data(1), 10'h0);
            repeat (20) @(negedge clk);
            chk($sformatf("row%0d_writes", i), act_q.size(), rows[i].writes);
            chk($sformatf("row%0d_words", i), pkt_words, rows[i].words);
            chk($sformatf("row%0d_done", i), done_cnt, rows[i].done);
            chk($sformatf("row%0d_err", i), err_cnt, rows[i].err);
            chk($sformatf("row%0d_src", i), pkt_src, src);
            check_model($sformatf("row%0d", i));
        end

`ifdef NI_RX_ADDR_CHECK_EN
        clear();
        for (int j = 0; j < 4; j++) begin
            f = j == 0 ? mk_head(8'h77, 8'h55, 8'd10) : mk_data(j == 3);
            chk($sformatf("drop_ready_before%0d", j), flit_ready, 1);
            send(f, 10'h0);
            chk($sformatf("drop_ready_after%0d", j), flit_ready, 1);
        end
        repeat (5) @(negedge clk);
        chk("drop_writes", act_q.size(), 0); chk("drop_done", done_cnt, 0);
        chk("drop_err", err_cnt, 1); chk("drop_src", pkt_src, 8'h77);
        m_in = 0; m_w = int'(pkt_words); m_src = pkt_src;
`endif

        clear();
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) f = mk_head(8'($urandom), LOCAL_ID, r < 3 ? 8'd255 : 8'($urandom_range(0, 40)));
            else if (r < 55) f = mk_data(0);
            else if (r < 90) f = mk_data(1);
            else begin f = rnd256(); f[255:254] = 2'b00; end
            send(f, 10'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check_model("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
